// File: rtl/aes_block_sequencer.sv
// Multi-block load / crypt / store sequencer for the AES HWPE.
// Moves num_blocks blocks word by word from the source stream, through the cipher core, to the sink stream.
module aes_block_sequencer #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WORD_BYTES      = 4,
    parameter int ADDR_W          = 32,
    parameter int NBLK_W          = 16,
    localparam int IDX_W          = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [NBLK_W-1:0] num_blocks_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_ready_i,
    input  logic              rd_done_i,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              wr_ready_i,
    input  logic              wr_done_i,
    output logic [IDX_W-1:0]  word_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        state_o
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_LOAD_REQ    = 4'd1;
    localparam logic [3:0] S_LOAD_WAIT   = 4'd2;
    localparam logic [3:0] S_CRYPT_START = 4'd3;
    localparam logic [3:0] S_CRYPT_WAIT  = 4'd4;
    localparam logic [3:0] S_STORE_REQ   = 4'd5;
    localparam logic [3:0] S_STORE_WAIT  = 4'd6;
    localparam logic [3:0] S_NEXT        = 4'd7;
    localparam logic [3:0] S_FINISH      = 4'd8;

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);

    // Handshake: a req output is a level held from REQ entry until ready is sampled high on a
    // rising edge; done (and eng_done) is honoured only in the matching WAIT state, never stored.
    logic [3:0]        state_q, state_d;
    logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [NBLK_W-1:0] nblk_q, nblk_d;
    logic [ADDR_W-1:0] word_off;

    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        word_cnt_d = word_cnt_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        nblk_d     = nblk_q;
        if (clear) begin
            state_d    = S_IDLE;
            blk_cnt_d  = '0;
            word_cnt_d = '0;
            src_base_d = '0;
            dst_base_d = '0;
            nblk_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_base_d = src_base_i;
                        dst_base_d = dst_base_i;
                        nblk_d     = num_blocks_i;
                        blk_cnt_d  = '0;
                        word_cnt_d = '0;
                        state_d    = (num_blocks_i == '0) ? S_FINISH : S_LOAD_REQ;
                    end
                end
                S_LOAD_REQ: begin
                    if (rd_ready_i) state_d = S_LOAD_WAIT;
                end
                S_LOAD_WAIT: begin
                    if (rd_done_i) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = S_CRYPT_START;
                        end else begin
                            word_cnt_d = word_cnt_q + IDX_W'(1);
                            state_d    = S_LOAD_REQ;
                        end
                    end
                end
                S_CRYPT_START: state_d = S_CRYPT_WAIT;
                S_CRYPT_WAIT: begin
                    if (eng_done_i) state_d = S_STORE_REQ;
                end
                S_STORE_REQ: begin
                    if (wr_ready_i) state_d = S_STORE_WAIT;
                end
                S_STORE_WAIT: begin
                    if (wr_done_i) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            state_d    = S_NEXT;
                        end else begin
                            word_cnt_d = word_cnt_q + IDX_W'(1);
                            state_d    = S_STORE_REQ;
                        end
                    end
                end
                S_NEXT: begin
                    // nblk_q is never zero here, so the subtraction cannot wrap.
                    if (blk_cnt_q == nblk_q - NBLK_W'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        blk_cnt_d = blk_cnt_q + NBLK_W'(1);
                        state_d   = S_LOAD_REQ;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            blk_cnt_q  <= '0;
            word_cnt_q <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            nblk_q     <= '0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            word_cnt_q <= word_cnt_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            nblk_q     <= nblk_d;
        end
    end

    // Byte offset of the current word, wrapping at ADDR_W bits.
    assign word_off = (ADDR_W'(blk_cnt_q) * ADDR_W'(WORDS_PER_BLOCK) + ADDR_W'(word_cnt_q))
                      * ADDR_W'(WORD_BYTES);

    assign rd_addr_o   = src_base_q + word_off;
    assign wr_addr_o   = dst_base_q + word_off;
    assign rd_req_o    = (state_q == S_LOAD_REQ);
    assign wr_req_o    = (state_q == S_STORE_REQ);
    assign eng_start_o = (state_q == S_CRYPT_START);
    assign done_o      = (state_q == S_FINISH);
    assign busy_o      = (state_q != S_IDLE);
    assign word_idx_o  = word_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer: stream responders with programmable delays, an address
// log checked against expected queues, and immediate assertions at every comparison point.
module tb_aes_block_sequencer;

    localparam int WPB = 4;
    localparam int WB  = 4;
    localparam int AW  = 32;
    localparam int NW  = 2;   // small count register so the all-ones count is reachable

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD_WAIT  = 4'd2;
    localparam logic [3:0] S_CRYPT_WAIT = 4'd4;
    localparam logic [3:0] S_STORE_WAIT = 4'd6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear = 1'b0;
    logic          start_drv = 1'b0;
    logic          spur_start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [NW-1:0] num_blocks = '0;
    logic          rd_req_o, eng_start_o, wr_req_o, busy_o, done_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [1:0]    word_idx_o;
    logic [3:0]    state_o;
    logic          rd_ready = 1'b0, rd_done_r = 1'b0, spur_rd_done = 1'b0;
    logic          wr_ready = 1'b0, wr_done_r = 1'b0, spur_wr_done = 1'b0;
    logic          eng_done_r = 1'b0, spur_eng_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int eng_cnt = 0;
    int start_cyc = 0;
    int dly_min = 0;
    int dly_max = 0;
    bit glitch_en = 1'b0;
    int rd0, wr0, e0, d0;

    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_log[$];
    logic [1:0]    rd_idx_log[$];
    int            eng_rd_q[$];
    int            eng_wr_q[$];

    aes_block_sequencer #(
        .WORDS_PER_BLOCK(WPB), .WORD_BYTES(WB), .ADDR_W(AW), .NBLK_W(NW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .start_i(start_drv | spur_start),
        .src_base_i(src_base), .dst_base_i(dst_base), .num_blocks_i(num_blocks),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_ready_i(rd_ready),
        .rd_done_i(rd_done_r | spur_rd_done),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_r | spur_eng_done),
        .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_ready_i(wr_ready),
        .wr_done_i(wr_done_r | spur_wr_done),
        .word_idx_o(word_idx_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    // Clock / cycle counter / done monitor
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Spurious pulses only outside the state that would honour them.
    always @(negedge clk) begin
        spur_rd_done  <= glitch_en && (state_o != S_LOAD_WAIT) && ($urandom_range(1, 0) == 1);
        spur_wr_done  <= glitch_en && (state_o != S_STORE_WAIT) && ($urandom_range(1, 0) == 1);
        spur_eng_done <= glitch_en && (state_o != S_CRYPT_WAIT) && ($urandom_range(1, 0) == 1);
        spur_start    <= glitch_en && busy_o && !done_o && ($urandom_range(1, 0) == 1);
    end

    // Source responder
    initial begin : rd_responder
        forever begin
            if (rd_req_o === 1'b1) begin
                repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
                rd_ready = 1'b1;
                rd_log.push_back(rd_addr_o);
                rd_idx_log.push_back(word_idx_o);
                @(negedge clk);
                rd_ready = 1'b0;
                repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
                rd_done_r = 1'b1;
                @(negedge clk);
                rd_done_r = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Sink responder
    initial begin : wr_responder
        forever begin
            if (wr_req_o === 1'b1) begin
                repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
                wr_ready = 1'b1;
                wr_log.push_back(wr_addr_o);
                @(negedge clk);
                wr_ready = 1'b0;
                repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
                wr_done_r = 1'b1;
                @(negedge clk);
                wr_done_r = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Engine responder
    initial begin : eng_responder
        forever begin
            if (eng_start_o === 1'b1) begin
                eng_cnt++;
                eng_rd_q.push_back(rd_log.size());
                eng_wr_q.push_back(wr_log.size());
                @(negedge clk);
                repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
                eng_done_r = 1'b1;
                @(negedge clk);
                eng_done_r = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [NW-1:0] nb);
        @(negedge clk);
        rd0 = rd_log.size();
        wr0 = wr_log.size();
        e0  = eng_cnt;
        d0  = done_cnt;
        src_base   = src;
        dst_base   = dst;
        num_blocks = nb;
        start_drv  = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start_drv  = 1'b0;
        src_base   = 32'hBAD0_0000;
        dst_base   = 32'hBAD1_0000;
        num_blocks = '0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_seq(input bit is_wr, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] got;
        int            sz;
        int            off;
        sz  = is_wr ? wr_log.size() - wr0 : rd_log.size() - rd0;
        off = is_wr ? wr0 : rd0;
        check(is_wr ? "wr_count" : "rd_count", 64'(sz), 64'(n));
        for (int i = 0; i < n; i++) exp_q.push_back(base + AW'(i * WB));
        for (int i = 0; i < n; i++) begin
            if (i < sz) got = is_wr ? wr_log[off + i] : rd_log[off + i];
            else        got = 'x;
            check(is_wr ? "wr_addr" : "rd_addr", 64'(got), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin : stimulus
        // Reset: async assertion, outputs idle before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_rd_req", 64'(rd_req_o), 64'd0);
        check("rst_wr_req", 64'(wr_req_o), 64'd0);
        check("rst_eng_start", 64'(eng_start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_word_idx", 64'(word_idx_o), 64'd0);
        check("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Single block, immediate responders.
        launch(32'h1000, 32'h2000, 2'd1);
        check("start_rd_req", 64'(rd_req_o), 64'd1);
        wait_done(200);
        check_seq(1'b0, 32'h1000, 4);
        check_seq(1'b1, 32'h2000, 4);
        for (int i = 0; i < 4; i++) check("rd_word_idx", 64'(rd_idx_log[rd0 + i]), 64'(i));
        check("single_eng", 64'(eng_cnt - e0), 64'd1);
        check("single_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("single_latency", 64'(done_cyc - start_cyc + 1), 64'd20);

        // Zero blocks: done next cycle, no traffic.
        launch(32'h1000, 32'h2000, 2'd0);
        wait_done(50);
        check("zero_latency", 64'(done_cyc - start_cyc + 1), 64'd1);
        check("zero_rd", 64'(rd_log.size() - rd0), 64'd0);
        check("zero_wr", 64'(wr_log.size() - wr0), 64'd0);
        check("zero_eng", 64'(eng_cnt - e0), 64'd0);

        // Three blocks (maximum count) with random 0-7 cycle delays, inputs scrambled mid-job.
        dly_min = 0;
        dly_max = 7;
        launch(32'h1000, 32'h3000, 2'd3);
        wait_done(3000);
        check_seq(1'b0, 32'h1000, 12);
        check_seq(1'b1, 32'h3000, 12);
        check("rand_eng", 64'(eng_cnt - e0), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check("eng_after_loads", 64'(eng_rd_q[e0 + k] - rd0), 64'(4 * (k + 1)));
            check("eng_after_stores", 64'(eng_wr_q[e0 + k] - wr0), 64'(4 * k));
        end
        check("rand_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Spurious done pulses and start re-assertion, immediate responders.
        dly_min = 0;
        dly_max = 0;
        glitch_en = 1'b1;
        repeat (3) @(negedge clk);
        launch(32'h4000, 32'h5000, 2'd2);
        wait_done(300);
        glitch_en = 1'b0;
        repeat (2) @(negedge clk);
        check_seq(1'b0, 32'h4000, 8);
        check_seq(1'b1, 32'h5000, 8);
        check("glitch_eng", 64'(eng_cnt - e0), 64'd2);
        check("glitch_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("glitch_latency", 64'(done_cyc - start_cyc + 1), 64'd39);
        check("glitch_idle", 64'(busy_o), 64'd0);

        // Clear during CRYPT_WAIT of block 2 of 3.
        dly_min = 4;
        dly_max = 4;
        launch(32'h1000, 32'h2000, 2'd3);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (eng_cnt - e0 >= 2) break;
        end
        check("clr_reached_blk2", 64'(eng_cnt - e0), 64'd2);
        @(negedge clk);
        check("clr_pre_state", 64'(state_o), 64'(S_CRYPT_WAIT));
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr_state", 64'(state_o), 64'(S_IDLE));
        check("clr_busy", 64'(busy_o), 64'd0);
        check("clr_word_idx", 64'(word_idx_o), 64'd0);
        check("clr_rd_addr", 64'(rd_addr_o), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        repeat (12) @(negedge clk);
        check("clr_no_done", 64'(done_cnt - d0), 64'd0);
        check("clr_stay_idle", 64'(busy_o), 64'd0);

        // Address wrap past 2^32.
        dly_min = 0;
        dly_max = 0;
        launch(32'hFFFF_FFF8, 32'hFFFF_FFF0, 2'd1);
        wait_done(200);
        check_seq(1'b0, 32'hFFFF_FFF8, 4);
        check_seq(1'b1, 32'hFFFF_FFF0, 4);
        check("wrap_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Asynchronous reset mid-job.
        launch(32'h1000, 32'h2000, 2'd2);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 64'(state_o), 64'(S_IDLE));
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_rd_req", 64'(rd_req_o), 64'd0);
        check("arst_rd_addr", 64'(rd_addr_o), 64'd0);
        check("arst_word_idx", 64'(word_idx_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_no_done", 64'(done_cnt - d0), 64'd0);
        check("arst_stay_idle", 64'(busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
